// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for a single external 16-bit async SRAM: port 0 fetch reads, port 1 load/store.
// One access at a time, round-robin on ties, all outputs (pins included) driven from registers.
module sram_port_arbiter #(
  parameter int READ_LAT = 2,
  parameter int AW       = 18,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [1:0]    p1_be,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] SRAM_A,
  inout  wire  [DW-1:0] SRAM_D,
  output logic          SRAM_CE,
  output logic          SRAM_OE,
  output logic          SRAM_WE,
  output logic          SRAM_LB,
  output logic          SRAM_UB
);

  localparam int CW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR1  = 2'd2,
    WR2  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            grant;
  logic            pick1;
  logic            rd_done;
  logic            rr_last;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_lat;
  logic [DW-1:0]   wdata_lat;
  logic [1:0]      be_lat;
  logic [1:0]      be_sel;
  logic            d_oe;
  logic [4:0]      strb_nx;

  // Arbitration and next state; a tie goes to the port that did not win last time.
  always_comb begin
    grant    = 1'b0;
    pick1    = 1'b0;
    state_nx = state;
    rd_done  = (state == RD) && (cnt == CNT_LAST);
    if ((state == IDLE) && (p0_req || p1_req)) begin
      grant = 1'b1;
      pick1 = p1_req && (!p0_req || !rr_last);
    end
    case (state)
      IDLE:    if (grant) state_nx = (pick1 && p1_we) ? WR1 : RD;
      RD:      if (rd_done) state_nx = IDLE;
      WR1:     state_nx = WR2;
      WR2:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes {CE,OE,WE,LB,UB} for the state being entered, so the pins change with the state.
  always_comb begin
    be_sel  = grant ? p1_be : be_lat;
    strb_nx = 5'b11111;
    case (state_nx)
      RD:      strb_nx = 5'b00100;
      WR1:     strb_nx = {1'b0, 1'b1, 1'b0, ~be_sel[0], ~be_sel[1]};
      WR2:     strb_nx = {1'b0, 1'b1, 1'b1, ~be_sel[0], ~be_sel[1]};
      default: strb_nx = 5'b11111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last   <= 1'b1;
      owner     <= 1'b0;
      cnt       <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      rdata     <= '0;
      addr_lat  <= '0;
      busy      <= 1'b0;
      d_oe      <= 1'b0;
      {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB} <= 5'b11111;
    end else begin
      p0_gnt    <= grant && !pick1;
      p1_gnt    <= grant && pick1;
      p0_rvalid <= rd_done && !owner;
      p1_rvalid <= rd_done && owner;
      busy      <= (state_nx != IDLE);
      d_oe      <= (state_nx == WR1) || (state_nx == WR2);
      {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB} <= strb_nx;
      if (grant) begin
        rr_last  <= pick1;
        owner    <= pick1;
        addr_lat <= pick1 ? p1_addr : p0_addr;
        cnt      <= '0;
      end else if (state == RD) begin
        cnt <= cnt + CW'(1);
      end
      if (rd_done) rdata <= SRAM_D;
    end
  end

  // Write payload needs no reset: it only reaches the pins while d_oe is set.
  always_ff @(posedge clk) begin
    if (grant && pick1) begin
      wdata_lat <= p1_wdata;
      be_lat    <= p1_be;
    end
  end

  assign SRAM_A = addr_lat;
  assign SRAM_D = d_oe ? wdata_lat : {DW{1'bz}};

endmodule
